// File: rtl/anc_pkg.sv
// Shared widths, default shift, FSM encoding and the 16-bit saturation helper
// for the ANC sample sequencer.
package anc_pkg;

   localparam int SAMPLE_W = 16;
   localparam int DATA_W   = 32;
   localparam int FRAC     = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_GO,
      ST_WAIT,
      ST_OUT
   } anc_state_t;

   localparam logic signed [DATA_W:0] SAT_MAX = 33'sd32767;
   localparam logic signed [DATA_W:0] SAT_MIN = -33'sd32768;

   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [DATA_W:0] v);
      logic signed [SAMPLE_W-1:0] r;
      if (v > SAT_MAX)
         r = 16'sh7fff;
      else if (v < SAT_MIN)
         r = 16'sh8000;
      else
         r = v[SAMPLE_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/anc_sat_neg.sv
// Negate a 32-bit FIR sample and clamp to 16 bits; combinational, no back-pressure.
// The negate is done one bit wider so -(-2^31) clamps instead of wrapping.
module anc_sat_neg
   import anc_pkg::*;
(
   input  logic signed [DATA_W-1:0]   din,
   output logic signed [SAMPLE_W-1:0] dout
);

   logic signed [DATA_W:0] neg;

   assign neg  = -((DATA_W+1)'(din));
   assign dout = sat16(neg);

endmodule

// File: rtl/anc_sample_sequencer.sv
// Sequences one ANC sample through the external LMS FIR: capture, weight term, FIR handshake, DAC.
// Latency 4 cycles plus FIR latency; ref_valid has no back-pressure, samples arriving while busy are dropped and counted.
module anc_sample_sequencer #(
   parameter logic signed [15:0] MU      = 16'sh0800,
   parameter int                 FRAC    = anc_pkg::FRAC,
   parameter int                 TIMEOUT = 255
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic signed [anc_pkg::SAMPLE_W-1:0] ref_in,
   input  logic signed [anc_pkg::SAMPLE_W-1:0] err_in,
   input  logic                                ref_valid,
   output logic signed [anc_pkg::DATA_W-1:0]   fir_feedforward,
   output logic signed [anc_pkg::DATA_W-1:0]   fir_weight_adjust,
   output logic                                fir_go,
   input  logic signed [anc_pkg::DATA_W-1:0]   fir_out,
   input  logic                                fir_out_valid,
   input  logic                                fir_done,
   output logic signed [anc_pkg::SAMPLE_W-1:0] dac_out,
   output logic                                dac_valid,
   output logic [7:0]                          overrun_cnt,
   output logic                                timeout_err
);

   import anc_pkg::*;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   anc_state_t                  state_q, state_d;
   logic signed [SAMPLE_W-1:0]  ref_q, err_q;
   logic signed [DATA_W-1:0]    fout_q;
   logic signed [DATA_W-1:0]    prod;
   logic signed [DATA_W-1:0]    sat_din;
   logic signed [SAMPLE_W-1:0]  sat_dout;
   logic [CNT_W-1:0]            wait_cnt;
   logic                        timeout_hit;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      fir_go      = 1'b0;
      dac_valid   = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: if (ref_valid) state_d = ST_CALC;
         ST_CALC: state_d = ST_GO;
         ST_GO: begin
            fir_go  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // done wins over a timeout landing in the same cycle
            if (fir_done)
               state_d = ST_OUT;
            else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               state_d     = ST_IDLE;
               timeout_hit = 1'b1;
            end
         end
         ST_OUT: begin
            dac_valid = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign prod = DATA_W'(err_q) * DATA_W'(MU);

   // A valid+done cycle must use that cycle's sample, not the stored one.
   assign sat_din = fir_out_valid ? fir_out : fout_q;

   anc_sat_neg u_sat_neg (
      .din  (sat_din),
      .dout (sat_dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_q             <= '0;
         err_q             <= '0;
         fout_q            <= '0;
         wait_cnt          <= '0;
         fir_feedforward   <= '0;
         fir_weight_adjust <= '0;
         dac_out           <= '0;
         overrun_cnt       <= '0;
         timeout_err       <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && ref_valid) begin
            ref_q <= ref_in;
            err_q <= err_in;
         end
         if (state_q == ST_CALC) begin
            fir_feedforward   <= DATA_W'(ref_q);
            fir_weight_adjust <= prod >>> FRAC;
         end
         if (state_q == ST_WAIT)
            wait_cnt <= wait_cnt + CNT_W'(1);
         else
            wait_cnt <= '0;
         if (state_q == ST_WAIT && fir_out_valid)
            fout_q <= fir_out;
         if (state_q == ST_WAIT && fir_done)
            dac_out <= sat_dout;
         if (ref_valid && state_q != ST_IDLE && overrun_cnt != 8'hff)
            overrun_cnt <= overrun_cnt + 8'd1;
         if (timeout_hit)
            timeout_err <= 1'b1;
      end
   end

endmodule
